// File: rtl/grey_pkg.sv
// Shared definitions for the grey-code decode monitor: direction codes,
// FSM state encoding and a width-generic grey-to-binary helper.
package grey_pkg;

  localparam logic [1:0] DIR_HOLD = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DN   = 2'b10;
  localparam logic [1:0] DIR_ERR  = 2'b11;

  localparam int GREY_MAX_W = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  // Only the low w bits of g are meaningful; upper result bits are zero.
  function automatic logic [GREY_MAX_W-1:0] grey2bin(input logic [GREY_MAX_W-1:0] g,
                                                     input int unsigned w);
    logic [GREY_MAX_W-1:0] b;
    logic                  acc;
    b   = '0;
    acc = 1'b0;
    for (int i = GREY_MAX_W - 1; i >= 0; i--) begin
      if (i < int'(w)) begin
        acc  = acc ^ g[i];
        b[i] = acc;
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/grey_to_bin.sv
// Combinational grey-to-binary decoder: each binary bit is the XOR of all
// grey bits at or above its position.
module grey_to_bin #(
  parameter int n = 3
) (
  input  logic [n-1:0] g,
  output logic [n-1:0] b
);

  always_comb begin
    logic acc;
    acc = 1'b0;
    b   = '0;
    for (int i = n - 1; i >= 0; i--) begin
      acc  = acc ^ g[i];
      b[i] = acc;
    end
  end

endmodule

// File: rtl/grey_decode_monitor.sv
// Registers and decodes a grey-coded sample, classifies the step against the
// previous accepted value and counts illegal steps. GREY_STICKY_ERR_EN adds err_sticky.
//
// state    | meaning
// ST_IDLE  | no reference sample yet; next valid sample is taken unchecked
// ST_TRACK | prev_b holds the last accepted value; every valid sample is checked
module grey_decode_monitor
  import grey_pkg::*;
#(
  parameter int n     = 3,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             g_valid,
  input  logic [n-1:0]     g,
  input  logic             err_clr,
  output logic             b_valid,
  output logic [n-1:0]     b,
  output logic [1:0]       dir,
  output logic             step_err,
  output logic [ERR_W-1:0] err_cnt
`ifdef GREY_STICKY_ERR_EN
  ,
  output logic             err_sticky
`endif
);

  state_t           state;
  logic [n-1:0]     prev_b;
  logic [n-1:0]     b_dec;
  logic [n-1:0]     prev_inc;
  logic [n-1:0]     prev_dec;
  logic [1:0]       dir_cls;
  logic [ERR_W-1:0] cnt_inc;

  grey_to_bin #(.n(n)) u_dec (
    .g (g),
    .b (b_dec)
  );

  assign prev_inc = prev_b + n'(1);
  assign prev_dec = prev_b - n'(1);

  // Up is tested before down so that n=1, where the two coincide, reads as up.
  always_comb begin
    dir_cls = DIR_ERR;
    if (b_dec == prev_b) begin
      dir_cls = DIR_HOLD;
    end else if (b_dec == prev_inc) begin
      dir_cls = DIR_UP;
    end else if (b_dec == prev_dec) begin
      dir_cls = DIR_DN;
    end
  end

  assign cnt_inc = (err_cnt == '1) ? err_cnt : err_cnt + ERR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      prev_b   <= '0;
      b_valid  <= 1'b0;
      b        <= '0;
      dir      <= DIR_HOLD;
      step_err <= 1'b0;
      err_cnt  <= '0;
`ifdef GREY_STICKY_ERR_EN
      err_sticky <= 1'b0;
`endif
    end else begin
      b_valid  <= g_valid;
      step_err <= 1'b0;
      dir      <= DIR_HOLD;
      if (err_clr) begin
        err_cnt <= '0;
`ifdef GREY_STICKY_ERR_EN
        err_sticky <= 1'b0;
`endif
      end
      if (g_valid) begin
        b      <= b_dec;
        prev_b <= b_dec;
        case (state)
          ST_IDLE: begin
            state <= ST_TRACK;
          end
          ST_TRACK: begin
            dir <= dir_cls;
            if (dir_cls == DIR_ERR) begin
              step_err <= 1'b1;
              // An error in the clearing cycle is counted after the clear.
              err_cnt  <= err_clr ? ERR_W'(1) : cnt_inc;
`ifdef GREY_STICKY_ERR_EN
              err_sticky <= 1'b1;
`endif
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_grey_decode_monitor.sv
// Self-checking bench for grey_decode_monitor: directed scenarios followed by
// random traffic, two instances (ERR_W=8 and ERR_W=2) on a shared stimulus.
module tb_grey_decode_monitor;

  localparam int N = 3;
  localparam int M = 1 << N;

  logic         clk = 1'b0;
  logic         rst;
  logic         g_valid;
  logic [N-1:0] g;
  logic         err_clr;

  logic         bv8, bv2;
  logic [N-1:0] b8, b2;
  logic [1:0]   dir8, dir2;
  logic         se8, se2;
  logic [7:0]   cnt8;
  logic [1:0]   cnt2;
`ifdef GREY_STICKY_ERR_EN
  logic         st8, st2;
`endif

  int total = 0;
  int bad   = 0;

  // reference model state
  bit m_trk;
  int m_prev, m_b, m_dir, m_bv, m_err, m_cnt8, m_cnt2, m_sticky;

  always #5 clk = ~clk;

  grey_decode_monitor #(.n(N), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .g_valid(g_valid), .g(g), .err_clr(err_clr),
    .b_valid(bv8), .b(b8), .dir(dir8), .step_err(se8), .err_cnt(cnt8)
`ifdef GREY_STICKY_ERR_EN
    , .err_sticky(st8)
`endif
  );

  grey_decode_monitor #(.n(N), .ERR_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .g_valid(g_valid), .g(g), .err_clr(err_clr),
    .b_valid(bv2), .b(b2), .dir(dir2), .step_err(se2), .err_cnt(cnt2)
`ifdef GREY_STICKY_ERR_EN
    , .err_sticky(st2)
`endif
  );

  // Reference decode by searching the grey encoding of every binary value.
  function automatic int ref_decode(int gv);
    for (int i = 0; i < M; i++) if ((i ^ (i >> 1)) == gv) return i;
    return -1;
  endfunction

  function automatic int to_grey(int bv);
    return (bv ^ (bv >> 1)) & (M - 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("b_valid", 32'(bv8), 32'(m_bv));
    chk("b", 32'(b8), 32'(m_b));
    chk("dir", 32'(dir8), 32'(m_dir));
    chk("step_err", 32'(se8), 32'(m_err));
    chk("err_cnt8", 32'(cnt8), 32'(m_cnt8));
    chk("w2_b", 32'(b2), 32'(m_b));
    chk("w2_dir", 32'(dir2), 32'(m_dir));
    chk("err_cnt2", 32'(cnt2), 32'(m_cnt2));
`ifdef GREY_STICKY_ERR_EN
    chk("sticky8", 32'(st8), 32'(m_sticky));
    chk("sticky2", 32'(st2), 32'(m_sticky));
`endif
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1; g_valid = 1'b0; err_clr = 1'b0; g = '0;
    repeat (cycles) @(posedge clk);
    #1;
    m_trk = 0; m_prev = 0; m_b = 0; m_dir = 0; m_bv = 0; m_err = 0;
    m_cnt8 = 0; m_cnt2 = 0; m_sticky = 0;
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input bit v, input int gv, input bit clr);
    int d, diff;
    @(negedge clk);
    g_valid = v; g = N'(gv); err_clr = clr;
    @(posedge clk);
    #1;
    m_bv = v; m_dir = 0; m_err = 0;
    if (v) begin
      d = ref_decode(gv);
      if (m_trk) begin
        diff = (d - m_prev + M) % M;
        if (diff == 0)          m_dir = 0;
        else if (diff == 1)     m_dir = 1;
        else if (diff == M - 1) m_dir = 2;
        else begin m_dir = 3; m_err = 1; end
      end
      m_trk = 1; m_prev = d; m_b = d;
    end
    if (m_err) begin
      m_cnt8 = clr ? 1 : ((m_cnt8 < 255) ? m_cnt8 + 1 : 255);
      m_cnt2 = clr ? 1 : ((m_cnt2 < 3) ? m_cnt2 + 1 : 3);
      m_sticky = 1;
    end else if (clr) begin
      m_cnt8 = 0; m_cnt2 = 0; m_sticky = 0;
    end
    check_all();
  endtask

  initial begin
    int up_seq[9];
    int r, bsel, nb;
    up_seq = '{0, 1, 3, 2, 6, 7, 5, 4, 0};
    rst = 1'b1; g_valid = 1'b0; g = '0; err_clr = 1'b0;

    // reset state
    do_reset(2);

    // up sequence incl. 7 -> 0 wrap
    foreach (up_seq[i]) step(1, up_seq[i], 0);
    chk("up_wrap_b", 32'(b8), 32'd0);
    chk("up_wrap_dir", 32'(dir8), 32'd1);

    // down sequence incl. 0 -> 7 wrap
    do_reset(1);
    for (int i = 8; i >= 0; i--) begin
      step(1, up_seq[i], 0);
      if (i == 7) begin
        chk("dn_wrap_b", 32'(b8), 32'd7);
        chk("dn_wrap_dir", 32'(dir8), 32'd2);
      end
    end
    chk("dn_cnt", 32'(cnt8), 32'd0);

    // illegal step, then resynchronised legal step
    do_reset(1);
    step(1, 3'b001, 0);
    step(1, 3'b101, 0);
    chk("ill_b", 32'(b8), 32'd6);
    chk("ill_dir", 32'(dir8), 32'd3);
    chk("ill_pulse", 32'(se8), 32'd1);
    chk("ill_cnt", 32'(cnt8), 32'd1);
    step(1, 3'b111, 0);
    chk("resync_dir", 32'(dir8), 32'd2);
    chk("resync_pulse", 32'(se8), 32'd0);

    // hold and gaps
    step(1, 3'b011, 0);
    step(1, 3'b011, 0);
    chk("hold_dir", 32'(dir8), 32'd0);
    repeat (3) step(0, 3'b000, 0);
    chk("gap_b", 32'(b8), 32'd2);
    chk("gap_bv", 32'(bv8), 32'd0);
    step(1, 3'b010, 0);
    chk("after_gap_dir", 32'(dir8), 32'd1);

    // counter saturation and clear rules
    do_reset(1);
    step(1, 0, 0);
    for (int i = 0; i < 6; i++) step(1, (i % 2 == 0) ? 6 : 0, 0);
    chk("sat_cnt2", 32'(cnt2), 32'd3);
    chk("cnt8_six", 32'(cnt8), 32'd6);
    step(1, 6, 1);
    chk("clr_err_cnt2", 32'(cnt2), 32'd1);
`ifdef GREY_STICKY_ERR_EN
    chk("clr_err_sticky", 32'(st2), 32'd1);
`endif
    step(0, 0, 1);
    chk("clr_only_cnt2", 32'(cnt2), 32'd0);

    // reset mid-stream
    step(1, 3'b011, 0);
    do_reset(1);
    step(1, 3'b110, 0);
    chk("post_rst_b", 32'(b8), 32'd4);
    chk("post_rst_dir", 32'(dir8), 32'd0);
    chk("post_rst_err", 32'(se8), 32'd0);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset(1);
      end else begin
        bsel = $urandom_range(0, 9);
        if (bsel < 3)      nb = m_prev;
        else if (bsel < 6) nb = (m_prev + 1) % M;
        else if (bsel < 8) nb = (m_prev + M - 1) % M;
        else               nb = $urandom_range(0, M - 1);
        step($urandom_range(0, 4) != 0, to_grey(nb), $urandom_range(0, 19) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/grey_decode_monitor.md
Name: grey_decode_monitor

Overview:
- Downstream consumer of the grey encoder. Registers an incoming n-bit grey code, decodes it to binary and checks it against the previous accepted code.
- Flags any step that is not a hold, +1 or -1 (modulo 2^n). Reports step direction and keeps a saturating error count.
- Sits between a grey-coded source (encoder, or a grey counter crossing a clock domain) and binary-consuming logic.

Parameters:
- n, 3, width of grey input and binary output
- ERR_W, 8, width of saturating error counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, active-high, synchronous
- g_valid  input  1  g is valid this cycle
- g  input  n  grey code sample
- err_clr  input  1  clears err_cnt (and err_sticky if present)
- b_valid  output  1  registered copy of g_valid
- b  output  n  registered binary decode of g
- dir  output  2  step classification for the current b (00 hold, 01 up, 10 down, 11 error)
- step_err  output  1  one-cycle pulse on an illegal step
- err_cnt  output  ERR_W  saturating count of illegal steps

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: b_valid=0, b=0, dir=00, step_err=0, err_cnt=0. Internal prev_b=0. State=IDLE.
- Decode: b_next[n-1]=g[n-1]; b_next[i]=b_next[i+1]^g[i]. Purely combinational before the output register.
- Latency: 1 cycle. A sample accepted at edge k appears on b/b_valid/dir/step_err after edge k.
- g_valid=0: b_valid=0, dir=00, step_err=0. b, prev_b, state and err_cnt hold.
- State IDLE (no reference sample):
  - On g_valid=1: output decode, dir=00, no check, prev_b<=decode, go to TRACK.
- State TRACK, on g_valid=1, with d=decode(g):
  - d==prev_b: dir=00.
  - d==prev_b+1 mod 2^n: dir=01 (includes wrap 2^n-1 -> 0).
  - d==prev_b-1 mod 2^n: dir=10 (includes wrap 0 -> 2^n-1).
  - Otherwise: dir=11, step_err=1, err_cnt increments.
  - In all cases prev_b<=d, so the next sample is checked against the new value (resynchronise, not lock up).
- n=1: +1 and -1 coincide; classify as up (01). Errors are impossible.
- err_cnt:
  - Saturates at 2^ERR_W-1; no wrap.
  - err_clr and an error in the same cycle give err_cnt=1.
  - err_clr alone gives 0.
- Reset mid-stream: all outputs return to reset values and state=IDLE. The first sample after reset is never flagged.
- Arithmetic: all step comparisons are n-bit modular. err_cnt is ERR_W-bit.

Optional Feature:
- Macro: GREY_STICKY_ERR_EN
- Defined:
  - Extra output err_sticky (1 bit), reset 0.
  - Set on the same edge step_err is asserted.
  - Cleared only by rst or err_clr.
  - err_clr together with an error leaves err_sticky=1.
- Undefined: port and its register are absent. All other behaviour is identical.

Decomposition:
- Package grey_pkg:
  - Direction codes DIR_HOLD=2'b00, DIR_UP=2'b01, DIR_DN=2'b10, DIR_ERR=2'b11.
  - State encoding ST_IDLE, ST_TRACK.
  - Function grey2bin (parameterised width).
- One sub-module: grey_to_bin. Combinational XOR-prefix decoder, parameter n, ports g in / b out. Instantiated once ahead of the output register.

Test Plan (n=3, ERR_W=8 unless noted):
- Up sequence: g=000,001,011,010,110,111,101,100,000 on consecutive cycles with g_valid=1. Expect b=0,1,2,...,7,0 one cycle later. dir=00 on the first sample, 01 on all others including 100->000 wrap. step_err never set.
- Down sequence: reverse of the above. Expect dir=10 throughout after the first sample, including the 000->100 wrap (b 0->7). err_cnt=0.
- Illegal step: g=001 then 101. Expect b=6, dir=11, step_err high exactly one cycle, err_cnt=1. Next g=111 (b=5) gives dir=10 with no error.
- Hold and gaps: g=011 twice, then g_valid=0 for 3 cycles, then g=010. Expect dir=00 for the repeat, b_valid=0 and b=2 held during the gap, then b=3 with dir=01.
- Counter rules, ERR_W=2:
  - Six illegal steps give err_cnt=3 (saturated).
  - err_clr together with an error gives err_cnt=1.
  - With GREY_STICKY_ERR_EN defined: err_sticky=1 after the first error; it stays high through the clr-with-error cycle and drops after a lone err_clr.
- Reset mid-stream: after g=011, assert rst for one cycle, then g=110. Expect all outputs 0 during reset, then b=4 with dir=00 and no error (IDLE re-entry).
